// File: rtl/msi_pkg.sv
// Shared types for the MSI L1 controller: line states, bus command codes,
// controller FSM states and the snoop response rules.
package msi_pkg;

    typedef enum logic [1:0] {
        LINE_I = 2'd0,
        LINE_S = 2'd1,
        LINE_M = 2'd2
    } line_state_e;

    localparam logic [1:0] CMD_NONE   = 2'd0;
    localparam logic [1:0] CMD_BUSRD  = 2'd1;
    localparam logic [1:0] CMD_BUSRDX = 2'd2;
    localparam logic [1:0] CMD_WB     = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        EVICT_REQ  = 3'd2,
        EVICT_WAIT = 3'd3,
        MISS_REQ   = 3'd4,
        MISS_WAIT  = 3'd5,
        RESP       = 3'd6
    } fsm_state_e;

    function automatic line_state_e snoop_next_state(input logic [1:0] cmd,
                                                     input line_state_e st);
        line_state_e nxt;
        nxt = st;
        if (cmd == CMD_BUSRD && st == LINE_M) begin
            nxt = LINE_S;
        end else if (cmd == CMD_BUSRDX && st != LINE_I) begin
            nxt = LINE_I;
        end
        return nxt;
    endfunction

    function automatic logic snoop_flushes(input logic [1:0] cmd,
                                           input line_state_e st);
        return (st == LINE_M) && (cmd == CMD_BUSRD || cmd == CMD_BUSRDX);
    endfunction

endpackage

// File: rtl/msi_line_array.sv
// Direct-mapped tag/state/data storage with one processor port and one
// combinational snoop lookup port; snoop state writes win on a shared index.
module msi_line_array
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 8,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [IDX_W-1:0]  p_idx,
    output logic [TAG_W-1:0]  p_tag,
    output line_state_e       p_state,
    output logic [DATA_W-1:0] p_data,
    input  logic              p_tag_we,
    input  logic [TAG_W-1:0]  p_tag_wr,
    input  logic              p_state_we,
    input  line_state_e       p_state_wr,
    input  logic              p_data_we,
    input  logic [DATA_W-1:0] p_data_wr,

    input  logic [IDX_W-1:0]  s_idx,
    output logic [TAG_W-1:0]  s_tag,
    output line_state_e       s_state,
    output logic [DATA_W-1:0] s_data,
    input  logic              s_state_we,
    input  line_state_e       s_state_wr
);

    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    line_state_e       state_q [NUM_LINES];
    logic [DATA_W-1:0] data_q  [NUM_LINES];

    assign p_tag   = tag_q[p_idx];
    assign p_state = state_q[p_idx];
    assign p_data  = data_q[p_idx];
    assign s_tag   = tag_q[s_idx];
    assign s_state = state_q[s_idx];
    assign s_data  = data_q[s_idx];

    // The snoop write is issued last so it overrides a processor write to the same line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= LINE_I;
            end
        end else begin
            if (p_state_we) begin
                state_q[p_idx] <= p_state_wr;
            end
            if (s_state_we) begin
                state_q[s_idx] <= s_state_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (p_tag_we) begin
            tag_q[p_idx] <= p_tag_wr;
        end
        if (p_data_we) begin
            data_q[p_idx] <= p_data_wr;
        end
    end

endmodule

// File: rtl/msi_l1_ctrl.sv
// MSI L1 cache controller: processor request FSM, bus master side and snoop responder.
//
// state      | meaning
// IDLE       | waiting for req; request fields latched on accept
// LOOKUP     | tag/state compare on the latched request
// EVICT_REQ  | bus requested for a dirty victim writeback
// EVICT_WAIT | writeback granted, waiting for bus_done
// MISS_REQ   | bus requested for BusRd/BusRdX
// MISS_WAIT  | fill granted, waiting for bus_done
// RESP       | drive ready/p_rdata for one cycle
module msi_l1_ctrl
    import msi_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int NUM_LINES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              p_func,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_done,
    input  logic              snp_valid,
    input  logic [1:0]        snp_cmd,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_flush,
    output logic [DATA_W-1:0] snp_data
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    fsm_state_e        state;
    logic [ADDR_W-1:0] req_addr;
    logic              req_func;
    logic [DATA_W-1:0] req_wdata;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  snp_idx;
    logic [TAG_W-1:0]  snp_tag;
    logic [1:0]        miss_cmd;

    logic [TAG_W-1:0]  line_tag;
    line_state_e       line_state;
    logic [DATA_W-1:0] line_data;
    logic [TAG_W-1:0]  snp_line_tag;
    line_state_e       snp_line_state;
    logic [DATA_W-1:0] snp_line_data;

    logic              p_tag_we;
    logic              p_state_we;
    line_state_e       p_state_wr;
    logic              p_data_we;
    logic [DATA_W-1:0] p_data_wr;

    logic              snp_hit;
    logic              snp_state_we;
    line_state_e       snp_state_wr;
    logic              snp_do_flush;
    logic              line_hit;
    logic              lookup_stall;
    logic              victim_snooped;

    assign req_idx  = req_addr[IDX_W-1:0];
    assign req_tag  = req_addr[ADDR_W-1:IDX_W];
    assign snp_idx  = snp_addr[IDX_W-1:0];
    assign snp_tag  = snp_addr[ADDR_W-1:IDX_W];
    assign miss_cmd = req_func ? CMD_BUSRDX : CMD_BUSRD;

    assign snp_hit        = snp_valid && (snp_line_state != LINE_I) && (snp_line_tag == snp_tag);
    assign snp_state_wr   = snoop_next_state(snp_cmd, snp_line_state);
    assign snp_state_we   = snp_hit && (snp_state_wr != snp_line_state);
    assign snp_do_flush   = snp_hit && snoop_flushes(snp_cmd, snp_line_state);
    assign line_hit       = (line_state != LINE_I) && (line_tag == req_tag);
    assign lookup_stall   = snp_valid && (snp_idx == req_idx);
    assign victim_snooped = snp_state_we && (snp_idx == req_idx);

    always_comb begin
        p_tag_we   = 1'b0;
        p_state_we = 1'b0;
        p_state_wr = LINE_I;
        p_data_we  = 1'b0;
        p_data_wr  = req_func ? req_wdata : bus_rdata;
        case (state)
            LOOKUP: begin
                if (!lookup_stall && req_func && line_hit && line_state == LINE_M) begin
                    p_data_we = 1'b1;
                end
            end
            EVICT_WAIT: begin
                if (bus_done) begin
                    p_state_we = 1'b1;
                end
            end
            MISS_WAIT: begin
                if (bus_done) begin
                    p_tag_we   = 1'b1;
                    p_data_we  = 1'b1;
                    p_state_we = 1'b1;
                    p_state_wr = req_func ? LINE_M : LINE_S;
                end
            end
            default: ;
        endcase
    end

    msi_line_array #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .p_idx      (req_idx),
        .p_tag      (line_tag),
        .p_state    (line_state),
        .p_data     (line_data),
        .p_tag_we   (p_tag_we),
        .p_tag_wr   (req_tag),
        .p_state_we (p_state_we),
        .p_state_wr (p_state_wr),
        .p_data_we  (p_data_we),
        .p_data_wr  (p_data_wr),
        .s_idx      (snp_idx),
        .s_tag      (snp_line_tag),
        .s_state    (snp_line_state),
        .s_data     (snp_line_data),
        .s_state_we (snp_state_we),
        .s_state_wr (snp_state_wr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_func  <= 1'b0;
            req_wdata <= '0;
            ready     <= 1'b0;
            p_rdata   <= '0;
            bus_req   <= 1'b0;
            bus_cmd   <= CMD_NONE;
            bus_addr  <= '0;
            bus_wdata <= '0;
            snp_flush <= 1'b0;
            snp_data  <= '0;
        end else begin
            ready     <= 1'b0;
            snp_flush <= snp_do_flush;
            snp_data  <= snp_do_flush ? snp_line_data : '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        req_addr  <= p_addr;
                        req_func  <= p_func;
                        req_wdata <= p_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!lookup_stall) begin
                        if (line_hit && (!req_func || line_state == LINE_M)) begin
                            state <= RESP;
                        end else if (!line_hit && line_state == LINE_M) begin
                            bus_req   <= 1'b1;
                            bus_cmd   <= CMD_WB;
                            bus_addr  <= {line_tag, req_idx};
                            bus_wdata <= line_data;
                            state     <= EVICT_REQ;
                        end else begin
                            // Covers both a clean miss and the S->M upgrade (write on S).
                            bus_req  <= 1'b1;
                            bus_cmd  <= miss_cmd;
                            bus_addr <= req_addr;
                            state    <= MISS_REQ;
                        end
                    end
                end
                EVICT_REQ: begin
                    if (victim_snooped) begin
                        bus_req <= 1'b0;
                        bus_cmd <= CMD_NONE;
                        state   <= MISS_REQ;
                    end else if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= EVICT_WAIT;
                    end
                end
                EVICT_WAIT: begin
                    if (bus_done) begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= miss_cmd;
                        bus_addr <= req_addr;
                        state    <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (bus_req && bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= MISS_WAIT;
                    end else begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= miss_cmd;
                        bus_addr <= req_addr;
                    end
                end
                MISS_WAIT: begin
                    if (bus_done) begin
                        bus_cmd <= CMD_NONE;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    ready   <= 1'b1;
                    p_rdata <= line_data;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_l1_ctrl.sv
// Directed bench for msi_l1_ctrl: a bus responder serves queued expected
// transactions and processor responses are checked against a read-data queue.
module tb_msi_l1_ctrl;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_RD   = 2'd1;
    localparam logic [1:0] C_RDX  = 2'd2;
    localparam logic [1:0] C_WB   = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       p_func = 1'b0;
    logic [7:0] p_addr = 8'h00;
    logic [7:0] p_wdata = 8'h00;
    logic       bus_gnt = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_done = 1'b0;
    logic       snp_valid = 1'b0;
    logic [1:0] snp_cmd = 2'd0;
    logic [7:0] snp_addr = 8'h00;

    logic [7:0] p_rdata;
    logic       ready;
    logic       bus_req;
    logic [1:0] bus_cmd;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       snp_flush;
    logic [7:0] snp_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } bus_txn_t;

    bus_txn_t   bq[$];
    logic [7:0] rq[$];

    always #5 clk = ~clk;

    msi_l1_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .NUM_LINES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .p_func    (p_func),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_rdata   (p_rdata),
        .ready     (ready),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_cmd   (bus_cmd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_done  (bus_done),
        .snp_valid (snp_valid),
        .snp_cmd   (snp_cmd),
        .snp_addr  (snp_addr),
        .snp_flush (snp_flush),
        .snp_data  (snp_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_snp_flush"}, snp_flush, 0);
        check({tag, "_bus_cmd"}, bus_cmd, 0);
        check({tag, "_bus_addr"}, bus_addr, 0);
        check({tag, "_bus_wdata"}, bus_wdata, 0);
        check({tag, "_p_rdata"}, p_rdata, 0);
        check({tag, "_snp_data"}, snp_data, 0);
    endtask

    task automatic exp_bus(input logic [1:0] cmd, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdata);
        bus_txn_t t;
        t.cmd = cmd; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        bq.push_back(t);
    endtask

    task automatic do_req(input logic func, input logic [7:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        req = 1'b1; p_func = func; p_addr = addr; p_wdata = wdata;
        @(negedge clk);
        req = 1'b0; p_func = ~func; p_addr = 8'hFF; p_wdata = 8'h00;
    endtask

    task automatic check_rd();
        logic [7:0] e;
        n_tests++;
        assert (rq.size() > 0) else begin
            n_fail++;
            $error("FAIL rd_queue: ready with p_rdata %0h, expected no response", p_rdata);
        end
        if (rq.size() > 0) begin
            e = rq.pop_front();
            check("p_rdata", p_rdata, e);
        end
    endtask

    task automatic serve_bus(input int gnt_delay);
        bus_txn_t t;
        t.cmd = C_NONE; t.addr = 8'h00; t.wdata = 8'h00; t.rdata = 8'h00;
        n_tests++;
        assert (bq.size() > 0) else begin
            n_fail++;
            $error("FAIL bus_queue: bus_cmd %0d addr %0h, expected no request", bus_cmd, bus_addr);
        end
        if (bq.size() > 0) t = bq.pop_front();
        check("bus_cmd", bus_cmd, t.cmd);
        check("bus_addr", bus_addr, t.addr);
        if (t.cmd == C_WB) check("bus_wdata", bus_wdata, t.wdata);
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            check("bus_req_hold", bus_req, 1);
            check("bus_addr_hold", bus_addr, t.addr);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("bus_req_drop", bus_req, 0);
        bus_done = 1'b1; bus_rdata = t.rdata;
        @(negedge clk);
        bus_done = 1'b0; bus_rdata = 8'h00;
    endtask

    task automatic run_until_ready(input int gnt_delay, output int cyc, output bit saw_bus);
        bit got;
        got = 1'b0; cyc = 0; saw_bus = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                got = 1'b1;
                check_rd();
            end else if (bus_req) begin
                saw_bus = 1'b1;
                serve_bus(gnt_delay);
            end
        end
        if (!got) begin
            n_tests++;
            assert (ready === 1'b1) else begin
                n_fail++;
                $error("FAIL ready_timeout: ready %b expected 1", ready);
            end
        end
        check("bus_queue_drained", bq.size(), 0);
    endtask

    task automatic txn(input logic func, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rdata, input int gnt_delay,
                       output int cyc, output bit saw_bus);
        rq.push_back(exp_rdata);
        do_req(func, addr, wdata);
        run_until_ready(gnt_delay, cyc, saw_bus);
    endtask

    task automatic snoop(input logic [1:0] cmd, input logic [7:0] addr,
                         input logic exp_flush, input logic [7:0] exp_data);
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = cmd; snp_addr = addr;
        @(negedge clk);
        snp_valid = 1'b0;
        check("snp_flush", snp_flush, exp_flush);
        check("snp_data", snp_data, exp_flush ? exp_data : 8'h00);
        @(negedge clk);
        check("snp_flush_one_cycle", snp_flush, 0);
    endtask

    task automatic wait_bus_req();
        int n;
        n = 0;
        while (bus_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bus_req_seen", bus_req, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit saw;
        bit quiet;

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        // Cold read: BusRd 0x10, fill A5.
        exp_bus(C_RD, 8'h10, 8'h00, 8'hA5);
        txn(1'b0, 8'h10, 8'h00, 8'hA5, 2, cyc, saw);

        // Write on S: BusRdX upgrade, written data overrides the fill.
        exp_bus(C_RDX, 8'h10, 8'h00, 8'hEE);
        txn(1'b1, 8'h10, 8'h3C, 8'h3C, 1, cyc, saw);

        // Read hit on M: two cycles, no bus activity.
        txn(1'b0, 8'h10, 8'h00, 8'h3C, 0, cyc, saw);
        check("hit_latency", cyc, 2);
        check("hit_no_bus", saw, 0);

        // Dirty eviction: WB 0x10/3C then BusRd 0x20.
        exp_bus(C_WB, 8'h10, 8'h3C, 8'h00);
        exp_bus(C_RD, 8'h20, 8'h00, 8'h77);
        txn(1'b0, 8'h20, 8'h00, 8'h77, 1, cyc, saw);

        // Write miss over a clean victim: BusRdX, line becomes M.
        exp_bus(C_RDX, 8'h10, 8'h00, 8'h11);
        txn(1'b1, 8'h10, 8'h3C, 8'h3C, 0, cyc, saw);

        // Snoops on the M line.
        snoop(C_RD, 8'h10, 1'b1, 8'h3C);
        snoop(C_RD, 8'h10, 1'b0, 8'h00);
        snoop(C_RDX, 8'h10, 1'b0, 8'h00);
        snoop(C_WB, 8'h10, 1'b0, 8'h00);

        // Line was invalidated: read misses with BusRd, no WB.
        exp_bus(C_RD, 8'h10, 8'h00, 8'h42);
        txn(1'b0, 8'h10, 8'h00, 8'h42, 0, cyc, saw);

        // Index 1: write miss, then write hit on M, snoop with other tag, read hit.
        exp_bus(C_RDX, 8'h05, 8'h00, 8'h00);
        txn(1'b1, 8'h05, 8'h99, 8'h99, 0, cyc, saw);
        txn(1'b1, 8'h05, 8'h66, 8'h66, 0, cyc, saw);
        check("write_hit_latency", cyc, 2);
        check("write_hit_no_bus", saw, 0);
        snoop(C_RDX, 8'h45, 1'b0, 8'h00);
        txn(1'b0, 8'h05, 8'h00, 8'h66, 0, cyc, saw);
        check("read_hit2_latency", cyc, 2);
        check("read_hit2_no_bus", saw, 0);

        // Make 0x10 dirty again (upgrade from S), then race a snoop against the WB.
        exp_bus(C_RDX, 8'h10, 8'h00, 8'hEE);
        txn(1'b1, 8'h10, 8'h3C, 8'h3C, 0, cyc, saw);
        rq.push_back(8'h81);
        exp_bus(C_RD, 8'h20, 8'h00, 8'h81);
        do_req(1'b0, 8'h20, 8'h00);
        wait_bus_req();
        check("race_wb_cmd", bus_cmd, C_WB);
        check("race_wb_addr", bus_addr, 8'h10);
        check("race_wb_data", bus_wdata, 8'h3C);
        snp_valid = 1'b1; snp_cmd = C_RDX; snp_addr = 8'h10;
        @(negedge clk);
        snp_valid = 1'b0;
        check("race_flush", snp_flush, 1);
        check("race_flush_data", snp_data, 8'h3C);
        check("race_bus_req_drop", bus_req, 0);
        run_until_ready(1, cyc, saw);

        // Reset while waiting for a fill.
        do_req(1'b0, 8'h30, 8'h00);
        wait_bus_req();
        check("rst_cmd", bus_cmd, C_RD);
        check("rst_addr", bus_addr, 8'h30);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ready) quiet = 1'b0;
        end
        check("rst_no_ready", quiet, 1);

        // After reset every line is I: both reads miss, no WB for the old M line.
        exp_bus(C_RD, 8'h30, 8'h00, 8'h33);
        txn(1'b0, 8'h30, 8'h00, 8'h33, 0, cyc, saw);
        exp_bus(C_RD, 8'h05, 8'h00, 8'h12);
        txn(1'b0, 8'h05, 8'h00, 8'h12, 0, cyc, saw);
        check("rd_queue_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
